matmul_feeder: RTL and testbench



---
 rtl/matmul_feeder_pkg.sv | 33 +++
 rtl/matmul_feeder_if.sv | 43 ++++
 rtl/matmul_feeder_lane.sv | 31 +++
 rtl/matmul_feeder.sv | 183 ++++++++++++++++++
 tb/tb_matmul_feeder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_feeder_pkg.sv
// Shared types and constants for the matmul operand feeder: FSM states,
// control register field positions and dimension helpers.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        DONE,
        WAIT_CLR
    } state_t;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_N_LSB     = 8;
    localparam int CTRL_N_MSB     = 9;
    localparam int CTRL_K_LSB     = 10;
    localparam int CTRL_K_MSB     = 11;
    localparam int CTRL_M_LSB     = 12;
    localparam int CTRL_M_MSB     = 13;

    localparam int DIM_W = CTRL_N_MSB - CTRL_N_LSB + 1;
    // Feed step counter; holds T_END = k+n+m <= 9 without wrapping.
    localparam int T_W   = 4;

    function automatic logic dim_out_of_range(input logic [DIM_W-1:0] f, input int max_dim);
        return int'(f) >= max_dim;
    endfunction

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] f, input int max_dim);
        return dim_out_of_range(f, max_dim) ? DIM_W'(max_dim - 1) : f;
    endfunction

endpackage

// File: rtl/matmul_feeder_if.sv
// Control/operand and array-edge signal bundle for matmul_feeder.
// dim_err_o exists only when MATMUL_FEEDER_DIM_CHECK_EN is defined.
interface matmul_feeder_if
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
);
    logic                            start_i;
    logic [DIM_W-1:0]                n_dim_i;
    logic [DIM_W-1:0]                k_dim_i;
    logic [DIM_W-1:0]                m_dim_i;
    logic [BUS_WIDTH*MAX_DIM-1:0]    operand_a_i;
    logic [BUS_WIDTH*MAX_DIM-1:0]    operand_b_i;
    logic [DATA_WIDTH*MAX_DIM-1:0]   a_o;
    logic [DATA_WIDTH*MAX_DIM-1:0]   b_o;
    logic                            valid_o;
    logic                            clear_o;
    logic                            eop_o;
    logic                            busy_o;
`ifdef MATMUL_FEEDER_DIM_CHECK_EN
    logic                            dim_err_o;

    modport master (
        output start_i, n_dim_i, k_dim_i, m_dim_i, operand_a_i, operand_b_i,
        input  a_o, b_o, valid_o, clear_o, eop_o, busy_o, dim_err_o
    );
    modport slave (
        input  start_i, n_dim_i, k_dim_i, m_dim_i, operand_a_i, operand_b_i,
        output a_o, b_o, valid_o, clear_o, eop_o, busy_o, dim_err_o
    );
`else
    modport master (
        output start_i, n_dim_i, k_dim_i, m_dim_i, operand_a_i, operand_b_i,
        input  a_o, b_o, valid_o, clear_o, eop_o, busy_o
    );
    modport slave (
        input  start_i, n_dim_i, k_dim_i, m_dim_i, operand_a_i, operand_b_i,
        output a_o, b_o, valid_o, clear_o, eop_o, busy_o
    );
`endif
endinterface

// File: rtl/matmul_feeder_lane.sv
// One skewed array-edge lane: picks element (t - LANE) of a row/column vector,
// or zero when outside the programmed limits.
module feeder_lane
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 4,
    parameter int LANE       = 0
) (
    input  logic [T_W-1:0]                 t,
    input  logic [DATA_WIDTH*MAX_DIM-1:0]  vec,
    input  logic [DIM_W-1:0]               outer_lim,
    input  logic [DIM_W-1:0]               inner_lim,
    output logic [DATA_WIDTH-1:0]          elem
);
    logic [T_W:0] diff;

    always_comb begin
        // Extra MSB of diff is the borrow: set when t < LANE.
        diff = {1'b0, t} - (T_W + 1)'(LANE);
        elem = '0;
        if (!diff[T_W] && (diff[T_W-1:0] <= T_W'(inner_lim)) &&
            ((T_W + 1)'(LANE) <= (T_W + 1)'(outer_lim))) begin
            for (int unsigned e = 0; e < MAX_DIM; e++) begin
                if (diff[T_W-1:0] == T_W'(e)) begin
                    elem = vec[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end
endmodule

// File: rtl/matmul_feeder.sv
// Operand skew/feed stage for the systolic matmul array.
// Define MATMUL_FEEDER_DIM_CHECK_EN to reject oversize dims via dim_err_o instead of clamping.
module matmul_feeder
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input logic            clk_i,
    input logic            rst_i,
    matmul_feeder_if.slave bus
);
    localparam int LANE_W = DATA_WIDTH * MAX_DIM;
    localparam int OP_W   = BUS_WIDTH * MAX_DIM;

    state_t           state_q;
    logic             start_q;
    logic             armed_q;
    logic [T_W-1:0]   t_q;
    logic [T_W-1:0]   t_sel;
    logic [T_W-1:0]   t_end;
    logic [DIM_W-1:0] n_q;
    logic [DIM_W-1:0] k_q;
    logic [DIM_W-1:0] m_q;
    logic [OP_W-1:0]  a_lat;
    logic [OP_W-1:0]  b_lat;
    logic [LANE_W-1:0] a_q;
    logic [LANE_W-1:0] b_q;
    logic [LANE_W-1:0] a_next;
    logic [LANE_W-1:0] b_next;
    logic             valid_q;
    logic             clear_q;
    logic             eop_q;
    logic             busy_q;
    logic             req;
    logic [LANE_W-1:0] a_row [MAX_DIM];
    logic [LANE_W-1:0] b_col [MAX_DIM];
`ifdef MATMUL_FEEDER_DIM_CHECK_EN
    logic             dim_err_q;
    logic             dims_bad;

    assign dims_bad = dim_out_of_range(bus.n_dim_i, MAX_DIM) |
                      dim_out_of_range(bus.k_dim_i, MAX_DIM) |
                      dim_out_of_range(bus.m_dim_i, MAX_DIM);
    assign bus.dim_err_o = dim_err_q;
`endif

    // armed_q blocks a start level still held high across reset from
    // looking like a fresh rising edge.
    assign req   = bus.start_i & ~start_q & armed_q;
    assign t_end = T_W'(n_q) + T_W'(k_q) + T_W'(m_q);
    assign t_sel = (state_q == LOAD) ? '0 : t_q + T_W'(1);

    always_comb begin
        for (int unsigned r = 0; r < MAX_DIM; r++) begin
            a_row[r] = a_lat[r*BUS_WIDTH +: LANE_W];
            b_col[r] = '0;
        end
        for (int unsigned c = 0; c < MAX_DIM; c++) begin
            for (int unsigned r = 0; r < MAX_DIM; r++) begin
                b_col[c][r*DATA_WIDTH +: DATA_WIDTH] = b_lat[r*BUS_WIDTH + c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
        feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .LANE(i)) u_a_lane (
            .t         (t_sel),
            .vec       (a_row[i]),
            .outer_lim (n_q),
            .inner_lim (k_q),
            .elem      (a_next[i*DATA_WIDTH +: DATA_WIDTH])
        );
        feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .LANE(i)) u_b_lane (
            .t         (t_sel),
            .vec       (b_col[i]),
            .outer_lim (m_q),
            .inner_lim (k_q),
            .elem      (b_next[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            armed_q   <= 1'b0;
            t_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            valid_q   <= 1'b0;
            clear_q   <= 1'b0;
            eop_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MATMUL_FEEDER_DIM_CHECK_EN
            dim_err_q <= 1'b0;
`endif
        end else begin
            start_q <= bus.start_i;
            armed_q <= armed_q | ~bus.start_i;
            case (state_q)
                IDLE: begin
                    a_q     <= '0;
                    b_q     <= '0;
                    valid_q <= 1'b0;
                    clear_q <= 1'b0;
                    eop_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    if (req) begin
                        a_lat  <= bus.operand_a_i;
                        b_lat  <= bus.operand_b_i;
                        n_q    <= clamp_dim(bus.n_dim_i, MAX_DIM);
                        k_q    <= clamp_dim(bus.k_dim_i, MAX_DIM);
                        m_q    <= clamp_dim(bus.m_dim_i, MAX_DIM);
                        busy_q <= 1'b1;
`ifdef MATMUL_FEEDER_DIM_CHECK_EN
                        if (dims_bad) begin
                            dim_err_q <= 1'b1;
                            state_q   <= WAIT_CLR;
                        end else begin
                            clear_q <= 1'b1;
                            state_q <= LOAD;
                        end
`else
                        clear_q <= 1'b1;
                        state_q <= LOAD;
`endif
                    end
                end
                LOAD: begin
                    clear_q <= 1'b0;
                    valid_q <= 1'b1;
                    a_q     <= a_next;
                    b_q     <= b_next;
                    t_q     <= '0;
                    state_q <= FEED;
                end
                FEED: begin
                    if (t_q == t_end) begin
                        valid_q <= 1'b0;
                        a_q     <= '0;
                        b_q     <= '0;
                        eop_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        t_q <= t_q + T_W'(1);
                        a_q <= a_next;
                        b_q <= b_next;
                    end
                end
                DONE: begin
                    eop_q   <= 1'b0;
                    state_q <= WAIT_CLR;
                end
                WAIT_CLR: begin
`ifdef MATMUL_FEEDER_DIM_CHECK_EN
                    dim_err_q <= 1'b0;
`endif
                    if (!bus.start_i) begin
                        busy_q  <= 1'b0;
                        t_q     <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a_o     = a_q;
    assign bus.b_o     = b_q;
    assign bus.valid_o = valid_q;
    assign bus.clear_o = clear_q;
    assign bus.eop_o   = eop_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_matmul_feeder.sv
// Self-checking bench for matmul_feeder: MAX_DIM=4 and MAX_DIM=2 instances,
// checked cycle by cycle against a matrix-level model of the feed schedule.
module tb_matmul_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int unsigned ref_a [4][4];
    int unsigned ref_b [4][4];

    always #5 clk = ~clk;

    matmul_feeder_if #(.DATA_WIDTH(8),  .BUS_WIDTH(32)) if4 ();
    matmul_feeder_if #(.DATA_WIDTH(16), .BUS_WIDTH(32)) if2 ();

    matmul_feeder #(.DATA_WIDTH(8),  .BUS_WIDTH(32)) dut4 (.clk_i(clk), .rst_i(rst), .bus(if4.slave));
    matmul_feeder #(.DATA_WIDTH(16), .BUS_WIDTH(32)) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) if2.start_i = v;
        else     if4.start_i = v;
    endtask

    task automatic check_outputs(input bit sel, input int cyc, input logic [63:0] ea, input logic [63:0] eb,
                                 input logic ev, input logic ec, input logic ee, input logic eb_busy,
                                 input logic eerr);
        logic [63:0] ga, gb;
        logic gv, gc, ge, gbusy, gerr;
        ga    = sel ? 64'(if2.a_o) : 64'(if4.a_o);
        gb    = sel ? 64'(if2.b_o) : 64'(if4.b_o);
        gv    = sel ? if2.valid_o : if4.valid_o;
        gc    = sel ? if2.clear_o : if4.clear_o;
        ge    = sel ? if2.eop_o   : if4.eop_o;
        gbusy = sel ? if2.busy_o  : if4.busy_o;
`ifdef MATMUL_FEEDER_DIM_CHECK_EN
        gerr  = sel ? if2.dim_err_o : if4.dim_err_o;
        check($sformatf("dim_err c%0d", cyc), 64'(gerr), 64'(eerr));
`else
        gerr  = 1'b0;
        if (eerr !== gerr) check($sformatf("dim_err_model c%0d", cyc), 64'(gerr), 64'(eerr));
`endif
        check($sformatf("a_o c%0d", cyc),     ga, ea);
        check($sformatf("b_o c%0d", cyc),     gb, eb);
        check($sformatf("valid_o c%0d", cyc), 64'(gv), 64'(ev));
        check($sformatf("clear_o c%0d", cyc), 64'(gc), 64'(ec));
        check($sformatf("eop_o c%0d", cyc),   64'(ge), 64'(ee));
        check($sformatf("busy_o c%0d", cyc),  64'(gbusy), 64'(eb_busy));
    endtask

    // Launch one request (start rises in c0) and compare every cycle with the model.
    // drop_at: cycle start_i goes low; glitch_at: 0/1 re-pulse; rst_at: reset cycle (-1 = none).
    task automatic run_op(input bit sel, input int n, input int k, input int m,
                          input int drop_at, input int glitch_at, input int rst_at);
        int md, dw, en, ek, em, tend, busy_end, last, t;
        bit err;
        logic [127:0] opa, opb;
        logic [63:0] mask, ea, eb;
        md = sel ? 2 : 4;
        dw = sel ? 16 : 8;
        mask = (64'd1 << dw) - 64'd1;
        err = 1'b0;
`ifdef MATMUL_FEEDER_DIM_CHECK_EN
        err = (n >= md) || (k >= md) || (m >= md);
`endif
        en = (n >= md) ? md - 1 : n;
        ek = (k >= md) ? md - 1 : k;
        em = (m >= md) ? md - 1 : m;
        tend = en + ek + em;
        if (err) busy_end = (drop_at > 1) ? drop_at : 1;
        else     busy_end = (drop_at > tend + 4) ? drop_at : tend + 4;
        last = busy_end + 2;
        opa = '0;
        opb = '0;
        for (int r = 0; r < md; r++)
            for (int c = 0; c < md; c++) begin
                opa |= 128'(ref_a[r][c] & mask) << (r*32 + c*dw);
                opb |= 128'(ref_b[r][c] & mask) << (r*32 + c*dw);
            end
        @(posedge clk); #1;
        if (sel) begin
            if2.operand_a_i = opa[63:0]; if2.operand_b_i = opb[63:0];
            if2.n_dim_i = 2'(n); if2.k_dim_i = 2'(k); if2.m_dim_i = 2'(m);
        end else begin
            if4.operand_a_i = opa; if4.operand_b_i = opb;
            if4.n_dim_i = 2'(n); if4.k_dim_i = 2'(k); if4.m_dim_i = 2'(m);
        end
        set_start(sel, 1'b1);
        for (int cyc = 0; cyc <= last; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (cyc == 1) begin
                if2.operand_a_i = {$urandom, $urandom};
                if2.operand_b_i = {$urandom, $urandom};
                if4.operand_a_i = {$urandom, $urandom, $urandom, $urandom};
                if4.operand_b_i = {$urandom, $urandom, $urandom, $urandom};
                if (sel) begin if2.n_dim_i = 2'($urandom); if2.k_dim_i = 2'($urandom); if2.m_dim_i = 2'($urandom); end
                else     begin if4.n_dim_i = 2'($urandom); if4.k_dim_i = 2'($urandom); if4.m_dim_i = 2'($urandom); end
            end
            if (cyc == glitch_at) set_start(sel, 1'b0);
            if (cyc == glitch_at + 1 && cyc < drop_at) set_start(sel, 1'b1);
            if (cyc == drop_at) set_start(sel, 1'b0);
            if (cyc == rst_at) rst = 1'b1;
            if (rst_at >= 0 && cyc == rst_at + 1) rst = 1'b0;
            @(negedge clk);
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                check_outputs(sel, cyc, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                break;
            end
            t = cyc - 2;
            ea = '0;
            eb = '0;
            if (!err && cyc >= 2 && cyc <= tend + 2) begin
                for (int i = 0; i < md; i++)
                    if (i <= en && t - i >= 0 && t - i <= ek)
                        ea |= (64'(ref_a[i][t-i]) & mask) << (i*dw);
                for (int j = 0; j < md; j++)
                    if (j <= em && t - j >= 0 && t - j <= ek)
                        eb |= (64'(ref_b[t-j][j]) & mask) << (j*dw);
            end
            check_outputs(sel, cyc, ea, eb,
                          !err && cyc >= 2 && cyc <= tend + 2,
                          !err && cyc == 1,
                          !err && cyc == tend + 3,
                          cyc >= 1 && cyc <= busy_end,
                          err && cyc == 1);
        end
    endtask

    // Idle cycles on the 4-lane instance: nothing may start or be driven.
    task automatic idle_check(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("%s busy c%0d", tag, c),  64'(if4.busy_o),  64'd0);
            check($sformatf("%s valid c%0d", tag, c), 64'(if4.valid_o), 64'd0);
            check($sformatf("%s clear c%0d", tag, c), 64'(if4.clear_o), 64'd0);
            check($sformatf("%s a_o c%0d", tag, c),   64'(if4.a_o),     64'd0);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ref_a[r][c] = $urandom;
                ref_b[r][c] = $urandom;
            end
    endtask

    initial begin
        int n, k, m;
        if4.start_i = 1'b1; if2.start_i = 1'b0;
        if4.n_dim_i = '0; if4.k_dim_i = '0; if4.m_dim_i = '0;
        if2.n_dim_i = '0; if2.k_dim_i = '0; if2.m_dim_i = '0;
        if4.operand_a_i = '0; if4.operand_b_i = '0;
        if2.operand_a_i = '0; if2.operand_b_i = '0;

        // Reset with start held high: outputs zero, no request afterwards.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c > 0) begin
                check("rst a_o", 64'(if4.a_o), 64'd0);
                check("rst b_o", 64'(if4.b_o), 64'd0);
                check("rst valid", 64'(if4.valid_o), 64'd0);
                check("rst clear", 64'(if4.clear_o), 64'd0);
                check("rst eop", 64'(if4.eop_o), 64'd0);
                check("rst busy", 64'(if4.busy_o), 64'd0);
                check("rst busy2", 64'(if2.busy_o), 64'd0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check("post_rst_held", 4);
        @(posedge clk); #1;
        if4.start_i = 1'b0;

        // 4x4x4, A[i][c]=i*4+c+1, B identity.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ref_a[r][c] = r*4 + c + 1;
                ref_b[r][c] = (r == c) ? 1 : 0;
            end
        run_op(1'b0, 3, 3, 3, 13, -1, -1);

        // 1x1x1 with padding junk elsewhere.
        fill_random();
        ref_a[0][0] = 32'h7F;
        ref_b[0][0] = 32'h02;
        run_op(1'b0, 0, 0, 0, 2, -1, -1);

        // Start re-pulsed mid-feed, then held high well past eop.
        fill_random();
        run_op(1'b0, 3, 2, 1, 13, 4, -1);

        // Reset at t=4 of a 4x4x4 run, start still high afterwards.
        fill_random();
        run_op(1'b0, 3, 3, 3, 30, -1, 6);
        idle_check("post_midrst", 3);
        @(posedge clk); #1;
        if4.start_i = 1'b0;
        fill_random();
        run_op(1'b0, 3, 3, 3, 5, -1, -1);

        // Random shapes on the 4-lane instance.
        for (int i = 0; i < 8; i++) begin
            fill_random();
            n = $urandom_range(0, 3);
            k = $urandom_range(0, 3);
            m = $urandom_range(0, 3);
            run_op(1'b0, n, k, m, $urandom_range(2, n + k + m + 6), -1, -1);
        end

        // MAX_DIM=2: out-of-range n, then random including oversize fields.
        fill_random();
        run_op(1'b1, 3, 0, 1, 3, -1, -1);
        for (int i = 0; i < 4; i++) begin
            fill_random();
            run_op(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(2, 9), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
